tower_square_object: RTL and testbench
======================================

Name: tower_square_object

Overview:
- Upstream of the tower bitmap stage: owns a single tower's screen position and lifecycle.
- Per pixel, produces the inside-rectangle flag and top-left-relative offsets that the bitmap stage consumes.
- Accepts placement requests via valid/ready handshake. Commits position only at frame start (no tearing).
- Animates a "build" by growing the visible height upward from the tower base, one step per frame.

Parameters:
OBJECT_WIDTH_X, 32, tower width in pixels
OBJECT_HEIGHT_Y, 64, tower height in pixels
GROW_STEP, 4, visible-height increment per frame while building
SCREEN_W, 640, screen width for placement range check
SCREEN_H, 480, screen height for placement range check

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixelX  in  11  current pixel column
pixelY  in  11  current pixel row
startOfFrame  in  1  one-cycle pulse at frame start
placeValid  in  1  placement request valid
placeReady  out  1  block can accept placement
placeX  in  11  requested top-left X
placeY  in  11  requested top-left Y
removeReq  in  1  one-cycle pulse requesting tower removal
placeError  out  1  one-cycle pulse: accepted request was out of range
InsideRectangle  out  1  pixel lies in visible tower area
offsetX  out  11  pixelX minus tower X (0 when outside)
offsetY  out  11  pixelY minus tower Y (0 when outside)
towerState  out  2  current FSM state
building  out  1  high in BUILDING

Behaviour:
- Reset (synchronous, active-high, wins over all inputs):
  - State EMPTY.
  - Active and pending positions, visH, and removePending all 0.
  - InsideRectangle, offsetX, offsetY, placeError all 0.
  - placeReady = (state==EMPTY) && !reset, so it is 0 during reset and 1 from the first cycle after.
- FSM states: EMPTY=0, PENDING=1, BUILDING=2, STANDING=3.
- EMPTY: a handshake occurs when placeValid && placeReady.
  - In range (placeX+OBJECT_WIDTH_X <= SCREEN_W and placeY+OBJECT_HEIGHT_Y <= SCREEN_H; sums computed 12-bit, no wrap): latch pending position, go PENDING.
  - Out of range: request is consumed; placeError pulses 1 cycle later; state stays EMPTY.
- PENDING: on startOfFrame, copy pending to active position, set visH=min(GROW_STEP, OBJECT_HEIGHT_Y), go BUILDING. If that value equals OBJECT_HEIGHT_Y, go STANDING directly.
  - removeReq in PENDING cancels immediately: next state EMPTY, position not committed.
- BUILDING: on startOfFrame, visH = min(visH+GROW_STEP, OBJECT_HEIGHT_Y), saturating. Go STANDING in the same cycle visH reaches OBJECT_HEIGHT_Y.
- STANDING: holds.
- Removal in BUILDING/STANDING:
  - removeReq sets removePending. On the next startOfFrame go EMPTY and clear visH and removePending.
  - removeReq coincident with startOfFrame removes in that cycle; removal takes priority over growth.
- placeReady=0 outside EMPTY. placeValid is ignored then.
- Hit test (state BUILDING or STANDING): inside when tx <= pixelX < tx+OBJECT_WIDTH_X and ty+OBJECT_HEIGHT_Y-visH <= pixelY < ty+OBJECT_HEIGHT_Y.
- Offsets are full-bitmap relative (offsetY = pixelY-ty), so the bitmap stage draws the base portion first.
- Outputs are registered, latency 1 cycle from pixelX/pixelY. Offsets are forced to 0 when not inside.
- Position and visH change only at startOfFrame (PENDING cancel aside), so a frame never mixes two positions.

Decomposition:
- Package tower_pkg:
  - state enum tower_state_t (EMPTY, PENDING, BUILDING, STANDING).
  - Coordinate width constant COORD_W=11.
  - Default tower dimensions and screen size constants.
- One sub-module: rect_hit_test.
  - Combinational: position, width, visible top/bottom, pixel in; inside flag and offsets out.
  - Top level registers its outputs.

Test Plan:
- Reset check: assert reset 3 cycles with placeValid=1 -> placeReady=0, InsideRectangle/offsets=0 during reset; placeReady=1 in first cycle after release; state EMPTY.
- Place (100,200), then startOfFrame -> state BUILDING, visH=4.
  - Pixel (110,260) -> next cycle InsideRectangle=1, offset=(10,60).
  - Pixel (110,259) -> InsideRectangle=0, offsets 0.
- Build completion: 16 startOfFrame pulses after placement -> STANDING, building=0.
  - Pixel (131,200) -> inside, offset (31,0).
  - Pixel (132,200) -> outside.
  - A 17th frame changes nothing.
- Out-of-range place (620,100) -> handshake completes, placeError=1 for exactly 1 cycle, state stays EMPTY, no pixel ever inside.
- Removal: removeReq in STANDING mid-frame -> pixel (110,230) still inside until next startOfFrame, then EMPTY, InsideRectangle=0, placeReady=1. Repeat with removeReq coincident with startOfFrame in BUILDING -> EMPTY that cycle, no growth.
- Cancel and mid-operation reset:
  - removeReq in PENDING -> EMPTY next cycle; next startOfFrame leaves nothing drawn.
  - Reset asserted mid-BUILDING -> EMPTY and InsideRectangle=0 on the cycle after the reset edge.

Source files
------------

// File: rtl/tower_pkg.sv
// Shared types and constants for the tower object block.
package tower_pkg;

   localparam int COORD_W         = 11;
   localparam int OBJECT_WIDTH_X  = 32;
   localparam int OBJECT_HEIGHT_Y = 64;
   localparam int GROW_STEP       = 4;
   localparam int SCREEN_W        = 640;
   localparam int SCREEN_H        = 480;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      PENDING  = 2'd1,
      BUILDING = 2'd2,
      STANDING = 2'd3
   } tower_state_t;

   // One extra bit on the sum so a far-right/bottom request cannot wrap into range.
   function automatic logic fits_on_screen(input logic [COORD_W-1:0] pos,
                                           input int size, input int limit);
      return ({1'b0, pos} + (COORD_W+1)'(size)) <= (COORD_W+1)'(limit);
   endfunction

endpackage

// File: rtl/rect_hit_test.sv
// Combinational hit test: pixel against a column-bounded, row-windowed rectangle.
module rect_hit_test
   import tower_pkg::*;
(
   input  logic [COORD_W-1:0] i_pos_x,
   input  logic [COORD_W-1:0] i_pos_y,
   input  logic [COORD_W:0]   i_width,
   input  logic [COORD_W:0]   i_vis_top,
   input  logic [COORD_W:0]   i_vis_bottom,
   input  logic [COORD_W-1:0] i_pixel_x,
   input  logic [COORD_W-1:0] i_pixel_y,
   output logic               o_inside,
   output logic [COORD_W-1:0] o_offset_x,
   output logic [COORD_W-1:0] o_offset_y
);

   logic [COORD_W:0] w_px;
   logic [COORD_W:0] w_py;
   logic [COORD_W:0] w_left;

   assign w_px   = {1'b0, i_pixel_x};
   assign w_py   = {1'b0, i_pixel_y};
   assign w_left = {1'b0, i_pos_x};

   assign o_inside = (w_px >= w_left) && (w_px < w_left + i_width) &&
                     (w_py >= i_vis_top) && (w_py < i_vis_bottom);

   // Offsets stay relative to the full bitmap origin, not the visible top.
   assign o_offset_x = o_inside ? (i_pixel_x - i_pos_x) : '0;
   assign o_offset_y = o_inside ? (i_pixel_y - i_pos_y) : '0;

endmodule

// File: rtl/tower_square_object.sv
// Single tower: placement handshake, frame-aligned commit, build animation, registered hit test.
//   state    | meaning
//   EMPTY    | no tower; accepting placement requests
//   PENDING  | position latched, waiting for frame start to commit
//   BUILDING | visible height growing by GROW_STEP each frame
//   STANDING | fully built, held until removed
module tower_square_object
   import tower_pkg::*;
#(
   parameter int P_WIDTH_X  = OBJECT_WIDTH_X,
   parameter int P_HEIGHT_Y = OBJECT_HEIGHT_Y,
   parameter int P_GROW     = GROW_STEP,
   parameter int P_SCREEN_W = SCREEN_W,
   parameter int P_SCREEN_H = SCREEN_H
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   input  logic               startOfFrame,
   input  logic               placeValid,
   output logic               placeReady,
   input  logic [COORD_W-1:0] placeX,
   input  logic [COORD_W-1:0] placeY,
   input  logic               removeReq,
   output logic               placeError,
   output logic               InsideRectangle,
   output logic [COORD_W-1:0] offsetX,
   output logic [COORD_W-1:0] offsetY,
   output logic [1:0]         towerState,
   output logic               building
);

   localparam logic [COORD_W-1:0] LP_H     = COORD_W'(P_HEIGHT_Y);
   localparam logic [COORD_W-1:0] LP_STEP  = COORD_W'(P_GROW);
   localparam logic [COORD_W-1:0] LP_FIRST = (P_GROW >= P_HEIGHT_Y) ? LP_H : LP_STEP;

   tower_state_t       r_state, w_state_nxt;
   logic [COORD_W-1:0] r_pend_x, r_pend_y, w_pend_x_nxt, w_pend_y_nxt;
   logic [COORD_W-1:0] r_act_x, r_act_y, w_act_x_nxt, w_act_y_nxt;
   logic [COORD_W-1:0] r_vis_h, w_vis_h_nxt;
   logic               r_rm_pend, w_rm_pend_nxt;
   logic               r_place_err, w_place_err_nxt;
   logic               r_inside;
   logic [COORD_W-1:0] r_off_x, r_off_y;

   logic               w_handshake, w_in_range, w_live, w_hit;
   logic [COORD_W-1:0] w_grown, w_hit_x, w_hit_y;
   logic [COORD_W:0]   w_vis_top, w_vis_bottom;

   assign placeReady  = (r_state == EMPTY) && !reset;
   assign w_handshake = placeValid && placeReady;
   assign w_in_range  = fits_on_screen(placeX, P_WIDTH_X, P_SCREEN_W) &&
                        fits_on_screen(placeY, P_HEIGHT_Y, P_SCREEN_H);
   assign w_grown     = ((r_vis_h + LP_STEP) >= LP_H) ? LP_H : (r_vis_h + LP_STEP);

   always_comb begin
      w_state_nxt     = r_state;
      w_pend_x_nxt    = r_pend_x;
      w_pend_y_nxt    = r_pend_y;
      w_act_x_nxt     = r_act_x;
      w_act_y_nxt     = r_act_y;
      w_vis_h_nxt     = r_vis_h;
      w_rm_pend_nxt   = r_rm_pend;
      w_place_err_nxt = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_handshake) begin
               if (w_in_range) begin
                  w_pend_x_nxt = placeX;
                  w_pend_y_nxt = placeY;
                  w_state_nxt  = PENDING;
               end else begin
                  w_place_err_nxt = 1'b1;
               end
            end
         end
         PENDING: begin
            if (removeReq) begin
               w_state_nxt = EMPTY;
            end else if (startOfFrame) begin
               w_act_x_nxt = r_pend_x;
               w_act_y_nxt = r_pend_y;
               w_vis_h_nxt = LP_FIRST;
               w_state_nxt = (LP_FIRST == LP_H) ? STANDING : BUILDING;
            end
         end
         default: begin
            // Removal is deferred to the frame boundary and beats growth.
            if ((removeReq || r_rm_pend) && startOfFrame) begin
               w_state_nxt   = EMPTY;
               w_vis_h_nxt   = '0;
               w_rm_pend_nxt = 1'b0;
            end else if (removeReq) begin
               w_rm_pend_nxt = 1'b1;
            end else if (startOfFrame && (r_state == BUILDING) && !r_rm_pend) begin
               w_vis_h_nxt = w_grown;
               if (w_grown == LP_H) w_state_nxt = STANDING;
            end
         end
      endcase
   end

   assign w_live       = (r_state == BUILDING) || (r_state == STANDING);
   assign w_vis_bottom = {1'b0, r_act_y} + (COORD_W+1)'(P_HEIGHT_Y);
   assign w_vis_top    = w_vis_bottom - {1'b0, r_vis_h};

   rect_hit_test u_hit (
      .i_pos_x      (r_act_x),
      .i_pos_y      (r_act_y),
      .i_width      ((COORD_W+1)'(P_WIDTH_X)),
      .i_vis_top    (w_vis_top),
      .i_vis_bottom (w_vis_bottom),
      .i_pixel_x    (pixelX),
      .i_pixel_y    (pixelY),
      .o_inside     (w_hit),
      .o_offset_x   (w_hit_x),
      .o_offset_y   (w_hit_y)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= EMPTY;
         r_pend_x    <= '0;
         r_pend_y    <= '0;
         r_act_x     <= '0;
         r_act_y     <= '0;
         r_vis_h     <= '0;
         r_rm_pend   <= 1'b0;
         r_place_err <= 1'b0;
         r_inside    <= 1'b0;
         r_off_x     <= '0;
         r_off_y     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pend_x    <= w_pend_x_nxt;
         r_pend_y    <= w_pend_y_nxt;
         r_act_x     <= w_act_x_nxt;
         r_act_y     <= w_act_y_nxt;
         r_vis_h     <= w_vis_h_nxt;
         r_rm_pend   <= w_rm_pend_nxt;
         r_place_err <= w_place_err_nxt;
         r_inside    <= w_live && w_hit;
         r_off_x     <= (w_live && w_hit) ? w_hit_x : '0;
         r_off_y     <= (w_live && w_hit) ? w_hit_y : '0;
      end
   end

   assign placeError      = r_place_err;
   assign InsideRectangle = r_inside;
   assign offsetX         = r_off_x;
   assign offsetY         = r_off_y;
   assign towerState      = r_state;
   assign building        = (r_state == BUILDING);

endmodule

// File: tb/tb_tower_square_object.sv
// Bench for tower_square_object: directed scenarios plus random traffic against a behavioural model.
module tb_tower_square_object;

   localparam int W = 32, H = 64, STEP = 4, SW = 640, SH = 480;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] pixelX = '0, pixelY = '0, placeX = '0, placeY = '0;
   logic        startOfFrame = 1'b0, placeValid = 1'b0, removeReq = 1'b0;
   logic        placeReady, placeError, InsideRectangle, building;
   logic [10:0] offsetX, offsetY;
   logic [1:0]  towerState;

   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;

   tower_square_object dut (
      .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
      .startOfFrame(startOfFrame), .placeValid(placeValid), .placeReady(placeReady),
      .placeX(placeX), .placeY(placeY), .removeReq(removeReq), .placeError(placeError),
      .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
      .towerState(towerState), .building(building)
   );

   always #5 clk = ~clk;

   // Model: what the tower should be doing, in plain integers.
   int m_state = 0, m_px = 0, m_py = 0, m_tx = 0, m_ty = 0, m_vis = 0;
   bit m_rm = 0;
   int e_in = 0, e_ox = 0, e_oy = 0, e_err = 0;

   always @(posedge clk) begin
      int px, py;
      bit hit;
      px = int'(pixelX);
      py = int'(pixelY);
      if (reset) begin
         m_state = 0; m_px = 0; m_py = 0; m_tx = 0; m_ty = 0; m_vis = 0; m_rm = 0;
         e_in = 0; e_ox = 0; e_oy = 0; e_err = 0;
      end else begin
         hit = (m_state >= 2) && px >= m_tx && px < m_tx + W &&
               py >= m_ty + H - m_vis && py < m_ty + H;
         e_in = hit ? 1 : 0;
         e_ox = hit ? px - m_tx : 0;
         e_oy = hit ? py - m_ty : 0;
         e_err = 0;
         if (m_state == 0) begin
            if (placeValid) begin
               if (int'(placeX) + W <= SW && int'(placeY) + H <= SH) begin
                  m_px = int'(placeX); m_py = int'(placeY); m_state = 1;
               end else e_err = 1;
            end
         end else if (m_state == 1) begin
            if (removeReq) m_state = 0;
            else if (startOfFrame) begin
               m_tx = m_px; m_ty = m_py;
               m_vis = (STEP < H) ? STEP : H;
               m_state = (m_vis == H) ? 3 : 2;
            end
         end else begin
            if ((removeReq || m_rm) && startOfFrame) begin
               m_state = 0; m_vis = 0; m_rm = 0;
            end else if (removeReq) m_rm = 1;
            else if (startOfFrame && m_state == 2) begin
               m_vis = (m_vis + STEP > H) ? H : m_vis + STEP;
               if (m_vis == H) m_state = 3;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_inside", int'(InsideRectangle), e_in);
         chk("model_offx", int'(offsetX), e_ox);
         chk("model_offy", int'(offsetY), e_oy);
         chk("model_err", int'(placeError), e_err);
         chk("model_state", int'(towerState), m_state);
         chk("model_building", int'(building), (m_state == 2) ? 1 : 0);
         chk("model_ready", int'(placeReady), (m_state == 0 && !reset) ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      placeValid = 0; startOfFrame = 0; removeReq = 0;
   endtask

   task automatic place(input int x, input int y);
      placeX = 11'(x); placeY = 11'(y); placeValid = 1;
      tick();
      placeValid = 0;
   endtask

   task automatic frame();
      startOfFrame = 1;
      tick();
      startOfFrame = 0;
      tick();
   endtask

   task automatic probe(input int x, input int y);
      pixelX = 11'(x); pixelY = 11'(y);
      tick();
   endtask

   initial begin
      reset = 1; placeValid = 1; placeX = 11'd100; placeY = 11'd200;
      tick();
      chk_en = 1;
      chk("rst_ready", int'(placeReady), 0);
      tick(); tick();
      chk("rst_inside", int'(InsideRectangle), 0);
      chk("rst_offx", int'(offsetX), 0);
      idle(); reset = 0; #1;
      chk("rel_ready", int'(placeReady), 1);
      chk("rel_state", int'(towerState), 0);

      place(100, 200);
      chk("pend_state", int'(towerState), 1);
      frame();
      chk("first_build_state", int'(towerState), 2);
      probe(110, 260);
      chk("p110_260_in", int'(InsideRectangle), 1);
      chk("p110_260_ox", int'(offsetX), 10);
      chk("p110_260_oy", int'(offsetY), 60);
      probe(110, 259);
      chk("p110_259_in", int'(InsideRectangle), 0);
      chk("p110_259_oy", int'(offsetY), 0);
      for (int i = 0; i < 14; i++) frame();
      chk("almost_built", int'(building), 1);
      frame();
      chk("built_state", int'(towerState), 3);
      chk("built_building", int'(building), 0);
      probe(131, 200);
      chk("p131_in", int'(InsideRectangle), 1);
      chk("p131_ox", int'(offsetX), 31);
      chk("p131_oy", int'(offsetY), 0);
      probe(132, 200);
      chk("p132_in", int'(InsideRectangle), 0);
      frame();
      chk("f17_state", int'(towerState), 3);
      probe(131, 200);
      chk("f17_in", int'(InsideRectangle), 1);

      removeReq = 1; tick(); removeReq = 0;
      probe(110, 230);
      chk("rmpend_in", int'(InsideRectangle), 1);
      chk("rmpend_state", int'(towerState), 3);
      startOfFrame = 1; tick(); startOfFrame = 0;
      chk("rm_state", int'(towerState), 0);
      chk("rm_ready", int'(placeReady), 1);
      tick();
      chk("rm_in", int'(InsideRectangle), 0);

      place(100, 200);
      frame();
      removeReq = 1; startOfFrame = 1; tick(); idle();
      chk("rm_sof_state", int'(towerState), 0);

      place(620, 100);
      chk("oor_err", int'(placeError), 1);
      chk("oor_state", int'(towerState), 0);
      tick();
      chk("oor_err_done", int'(placeError), 0);
      frame();
      probe(625, 130);
      chk("oor_in", int'(InsideRectangle), 0);

      place(100, 200);
      removeReq = 1; tick(); removeReq = 0;
      chk("cancel_state", int'(towerState), 0);
      frame();
      probe(110, 263);
      chk("cancel_in", int'(InsideRectangle), 0);

      place(100, 200);
      frame();
      probe(110, 263);
      chk("pre_rst_in", int'(InsideRectangle), 1);
      reset = 1; tick(); reset = 0;
      chk("mid_rst_state", int'(towerState), 0);
      chk("mid_rst_in", int'(InsideRectangle), 0);

      for (int i = 0; i < 4000; i++) begin
         reset        = ($urandom_range(0, 399) == 0);
         placeValid   = ($urandom_range(0, 3) == 0);
         placeX       = 11'($urandom_range(0, 1) ? $urandom_range(590, 700) : $urandom_range(0, 640));
         placeY       = 11'($urandom_range(0, 1) ? $urandom_range(400, 500) : $urandom_range(0, 480));
         startOfFrame = ($urandom_range(0, 5) == 0);
         removeReq    = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 1)) begin
            pixelX = 11'(m_tx + $urandom_range(0, 40) - 4);
            pixelY = 11'(m_ty + $urandom_range(0, 72) - 4);
         end else begin
            pixelX = 11'($urandom_range(0, 2047));
            pixelY = 11'($urandom_range(0, 2047));
         end
         tick();
      end
      idle(); reset = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
